// File: rtl/mul_div_pkg.sv
// Shared types and helpers for the sequential multiply/divide unit.
package mul_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Width of the iteration counter: it must hold the larger operand width.
    function automatic int cnt_width(input int n1, input int n2);
        int m;
        m = (n1 > n2) ? n1 : n2;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// Shift-add multiplier and restoring divider registers, one bit per step.
// o_result_next is the packed result as it will be after the current step,
// so the controller can capture it on the final iteration edge.
module mul_div_datapath
    import mul_div_pkg::*;
#(
    parameter int N1 = 8,
    parameter int N2 = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_mode,
    input  logic [N1-1:0]    i_oper_x,
    input  logic [N2-1:0]    i_oper_y,
    output logic [N1+N2-1:0] o_result_next
);

    localparam int W = N1 + N2;

    logic [W-1:0]  r_acc;   // product accumulator
    logic [W-1:0]  r_xs;    // multiplicand, shifted left each step
    logic [N2-1:0] r_y;     // multiplier (shifted right) or divisor (static)
    logic [N2-1:0] r_rem;   // partial remainder; always < divisor
    logic [N1-1:0] r_q;     // dividend bits out at the top, quotient bits in at the bottom

    logic [W-1:0]  w_acc_next;
    logic [N2:0]   w_shifted;
    logic [N2:0]   w_trial;
    logic          w_neg;
    logic [N2-1:0] w_rem_next;
    logic [N1-1:0] w_q_next;

    // One iteration of each algorithm. Since the remainder is below the
    // divisor, the shifted value is below twice the divisor, so bit N2 of
    // the trial difference is exactly its sign.
    always_comb begin
        w_acc_next    = r_acc + (r_y[0] ? r_xs : '0);
        w_shifted     = {r_rem, r_q[N1-1]};
        w_trial       = w_shifted - {1'b0, r_y};
        w_neg         = w_trial[N2];
        w_rem_next    = w_neg ? w_shifted[N2-1:0] : w_trial[N2-1:0];
        w_q_next      = (r_q << 1) | N1'(!w_neg);
        o_result_next = (i_mode == MODE_DIV) ? {w_rem_next, w_q_next} : w_acc_next;
    end

    // Operand load on accept, then one algorithm step per RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
            r_xs  <= '0;
            r_y   <= '0;
            r_rem <= '0;
            r_q   <= '0;
        end else if (i_load) begin
            r_acc <= '0;
            r_xs  <= W'(i_oper_x);
            r_y   <= i_oper_y;
            r_rem <= '0;
            r_q   <= i_oper_x;
        end else if (i_step) begin
            if (i_mode == MODE_MUL) begin
                r_acc <= w_acc_next;
                r_xs  <= r_xs << 1;
                r_y   <= r_y >> 1;
            end else begin
                r_rem <= w_rem_next;
                r_q   <= w_q_next;
            end
        end
    end

endmodule

// File: rtl/seq_mul_div.sv
// Sequential unsigned multiply/divide unit with Start/Busy/Done handshake.
// Handshake: Start is only looked at in IDLE or DONE; an accepted request
// raises Busy from the next cycle, and Done pulses for one cycle when Result
// and DivByZero have been updated. Start during RUN is ignored.
module seq_mul_div
    import mul_div_pkg::*;
#(
    parameter int OPER1_LENGTH = 8,
    parameter int OPER2_LENGTH = 8
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 Start,
    input  logic                                 Mode,
    input  logic [OPER1_LENGTH-1:0]              OperX,
    input  logic [OPER2_LENGTH-1:0]              OperY,
    output logic                                 Busy,
    output logic                                 Done,
    output logic                                 DivByZero,
    output logic [OPER1_LENGTH+OPER2_LENGTH-1:0] Result,
    output state_t                               DbgState
);

    localparam int W  = OPER1_LENGTH + OPER2_LENGTH;
    localparam int CW = cnt_width(OPER1_LENGTH, OPER2_LENGTH);
    localparam logic [CW-1:0] L_MUL = CW'(OPER2_LENGTH);
    localparam logic [CW-1:0] L_DIV = CW'(OPER1_LENGTH);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_cnt;
    logic          r_mode;
    logic          w_accept;
    logic          w_dz;
    logic          w_finish;
    logic [W-1:0]  w_result_next;

    assign DbgState = r_state;

    // Next-state decode, accept/finish strobes and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        Busy         = 1'b0;
        Done         = 1'b0;
        w_dz         = (Mode == MODE_DIV) && (OperY == '0);
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_dz ? DONE : RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_finish     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                Done = 1'b1;
                if (Start) begin
                    w_accept     = 1'b1;
                    w_next_state = w_dz ? DONE : RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Iteration counter and latched operation mode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_mode <= MODE_MUL;
        end else if (w_accept) begin
            r_mode <= Mode;
            r_cnt  <= w_dz ? '0 : ((Mode == MODE_DIV) ? L_DIV : L_MUL);
        end else if (r_state == RUN) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result registers change only when entering DONE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Result    <= '0;
            DivByZero <= 1'b0;
        end else if (w_accept && w_dz) begin
            Result    <= '1;
            DivByZero <= 1'b1;
        end else if (w_finish) begin
            Result    <= w_result_next;
            DivByZero <= 1'b0;
        end
    end

    mul_div_datapath #(
        .N1(OPER1_LENGTH),
        .N2(OPER2_LENGTH)
    ) u_datapath (
        .i_clk         (CLK),
        .i_rst         (RST),
        .i_load        (w_accept),
        .i_step        (r_state == RUN),
        .i_mode        (r_mode),
        .i_oper_x      (OperX),
        .i_oper_y      (OperY),
        .o_result_next (w_result_next)
    );

endmodule

// File: tb/tb_seq_mul_div.sv
// Bench for seq_mul_div: an 8x8 instance checked every cycle against a
// transaction-level model, and a 6x3 instance checked per operation.
module tb_seq_mul_div;
    import mul_div_pkg::*;

    typedef struct {
        int          s;
        int          l;
        logic [31:0] res;
        bit          dz;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 8x8 ----------------
    logic        s8 = 0, m8 = 0;
    logic [7:0]  x8 = 0, y8 = 0;
    logic        busy8, done8, dz8;
    logic [15:0] res8;
    state_t      st8;

    seq_mul_div #(.OPER1_LENGTH(8), .OPER2_LENGTH(8)) dut8 (
        .CLK(clk), .RST(rst), .Start(s8), .Mode(m8), .OperX(x8), .OperY(y8),
        .Busy(busy8), .Done(done8), .DivByZero(dz8), .Result(res8), .DbgState(st8)
    );

    // ---------------- DUT 6x3 ----------------
    logic        sb = 0, mb = 0;
    logic [5:0]  xb = 0;
    logic [2:0]  yb = 0;
    logic        busyb, doneb, dzb;
    logic [8:0]  resb;
    state_t      stb;

    seq_mul_div #(.OPER1_LENGTH(6), .OPER2_LENGTH(3)) dutb (
        .CLK(clk), .RST(rst), .Start(sb), .Mode(mb), .OperX(xb), .OperY(yb),
        .Busy(busyb), .Done(doneb), .DivByZero(dzb), .Result(resb), .DbgState(stb)
    );

    // ---------------- scoreboard ----------------
    int chk_cnt = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Reference: plain arithmetic on the operation definition.
    function automatic logic [31:0] ref_op(input bit mode, input int x, input int y,
                                           input int n1, input int n2);
        if (!mode) return 32'(x * y);
        if (y == 0) return 32'((64'(1) << (n1 + n2)) - 64'(1));
        return 32'(((x % y) << n1) | (x / y));
    endfunction

    function automatic int ref_len(input bit mode, input int y, input int n1, input int n2);
        if (!mode) return n2;
        return (y == 0) ? 0 : n1;
    endfunction

    exp_t        exp_q[$];
    exp_t        f;
    bit          eb, ed;
    logic [31:0] held_res = 0;
    bit          held_dz = 0;
    bit          cmp_en = 0;
    int          last_end = 0;
    int          last_done_cyc = -1;
    int          done_seen = 0;

    // Per-cycle comparison of the 8x8 instance against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            eb = 0;
            ed = 0;
            if (exp_q.size() > 0) begin
                f  = exp_q[0];
                eb = (cyc > f.s) && (cyc <= f.s + f.l);
                ed = (cyc == f.s + f.l + 1);
            end
            check("busy", 32'(busy8), 32'(eb));
            check("done", 32'(done8), 32'(ed));
            if (ed) begin
                held_res = f.res;
                held_dz  = f.dz;
                void'(exp_q.pop_front());
            end
            check("result", 32'(res8), held_res);
            check("divbyzero", 32'(dz8), 32'(held_dz));
        end
        if (done8) begin
            last_done_cyc = cyc;
            done_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue8(input bit mode, input int x, input int y);
        exp_t e;
        s8 = 1'b1; m8 = mode; x8 = x[7:0]; y8 = y[7:0];
        e.s   = cyc;
        e.l   = ref_len(mode, y, 8, 8);
        e.res = ref_op(mode, x, y, 8, 8);
        e.dz  = mode && (y == 0);
        exp_q.push_back(e);
        last_end = e.s + e.l + 1;
        @(negedge clk);
        s8 = 1'b0;
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            check("idle_timeout", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_until8(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic run_b(input bit mode, input int x, input int y, output int lat);
        int s, n;
        logic [31:0] er;
        sb = 1'b1; mb = mode; xb = x[5:0]; yb = y[2:0];
        s = cyc;
        @(negedge clk);
        sb = 1'b0;
        n = 0;
        while (!doneb && n < 40) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - s;
        er  = ref_op(mode, x, y, 6, 3);
        check("b_latency", 32'(lat), 32'(ref_len(mode, y, 6, 3) + 1));
        check("b_result", 32'(resb), er);
        check("b_divbyzero", 32'(dzb), 32'(mode && (y == 0)));
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s0, lat, x, y, gap;
        bit mode, b2b;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy8), 32'(0));
        check("rst_done", 32'(done8), 32'(0));
        check("rst_result", 32'(res8), 32'(0));
        check("rst_dz", 32'(dz8), 32'(0));
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // 13 x 11 with an ignored Start at cycle 3
        s0 = cyc;
        issue8(MODE_MUL, 13, 11);
        wait_until8(s0 + 3);
        s8 = 1'b1; m8 = MODE_MUL; x8 = 8'd1; y8 = 8'd1;
        @(negedge clk);
        s8 = 1'b0;
        wait_idle8();
        check("lit_13x11", 32'(res8), 32'd143);
        check("lit_13x11_lat", 32'(last_done_cyc - s0), 32'd9);

        // 255 x 255, then 0 x 200 back-to-back in the DONE cycle
        issue8(MODE_MUL, 255, 255);
        wait_until8(last_end);
        check("lit_255x255", 32'(res8), 32'hFE01);
        s0 = cyc;
        issue8(MODE_MUL, 0, 200);
        wait_idle8();
        check("lit_0x200", 32'(res8), 32'd0);
        check("lit_0x200_lat", 32'(last_done_cyc - s0), 32'd9);

        // Divides
        s0 = cyc;
        issue8(MODE_DIV, 200, 7);
        wait_idle8();
        check("lit_200div7", 32'(res8), 32'h041C);
        check("lit_200div7_lat", 32'(last_done_cyc - s0), 32'd9);
        issue8(MODE_DIV, 5, 9);
        wait_idle8();
        check("lit_5div9", 32'(res8), 32'h0500);
        s0 = cyc;
        issue8(MODE_DIV, 77, 0);
        wait_idle8();
        check("lit_77div0", 32'(res8), 32'hFFFF);
        check("lit_77div0_dz", 32'(dz8), 32'd1);
        check("lit_77div0_lat", 32'(last_done_cyc - s0), 32'd1);
        issue8(MODE_MUL, 2, 3);
        wait_idle8();
        check("lit_2x3", 32'(res8), 32'd6);
        check("lit_2x3_dz", 32'(dz8), 32'd0);

        // Reset in the middle of 13 x 11
        s0 = cyc;
        issue8(MODE_MUL, 13, 11);
        wait_until8(s0 + 5);
        cmp_en = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy8), 32'(0));
        check("midrst_done", 32'(done8), 32'(0));
        check("midrst_result", 32'(res8), 32'(0));
        exp_q.delete();
        held_res = 0;
        held_dz = 0;
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        done_seen = 0;
        repeat (12) @(negedge clk);
        check("midrst_no_done", 32'(done_seen), 32'(0));

        // Randomised traffic on the 8x8 instance
        for (int i = 0; i < 80; i++) begin
            mode = 1'($urandom_range(0, 1));
            x    = int'($urandom_range(0, 255));
            y    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            b2b  = ($urandom_range(0, 2) == 0);
            if (b2b && exp_q.size() > 0) begin
                wait_until8(last_end);
            end else begin
                wait_idle8();
                gap = int'($urandom_range(0, 3));
                repeat (gap) @(negedge clk);
            end
            issue8(mode, x, y);
            if ($urandom_range(0, 3) == 0 && ref_len(mode, y, 8, 8) >= 1) begin
                s8 = 1'b1; m8 = 1'($urandom_range(0, 1));
                x8 = 8'($urandom_range(0, 255)); y8 = 8'($urandom_range(0, 255));
                @(negedge clk);
                s8 = 1'b0;
            end
        end
        wait_idle8();

        // 6x3 instance
        run_b(MODE_MUL, 63, 7, lat);
        check("lit_b_63x7", 32'(resb), 32'd441);
        check("lit_b_63x7_lat", 32'(lat), 32'd4);
        run_b(MODE_DIV, 63, 5, lat);
        check("lit_b_63div5", 32'(resb), 32'd204);
        check("lit_b_63div5_lat", 32'(lat), 32'd7);
        run_b(MODE_DIV, 9, 0, lat);
        check("lit_b_9div0", 32'(resb), 32'h1FF);
        for (int i = 0; i < 20; i++) begin
            mode = 1'($urandom_range(0, 1));
            x    = int'($urandom_range(0, 63));
            y    = int'($urandom_range(0, 7));
            run_b(mode, x, y, lat);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seq_mul_div.md
Name: seq_mul_div

Overview:
- Parametrised sequential arithmetic unit that replaces the combinational multiplier in the multiplier/divider core.
- Performs unsigned multiply (shift-add) or unsigned divide (restoring), one bit per clock.
- Operands are independent widths. Operation is selected per transaction; a Start/Busy/Done handshake connects it to the surrounding controller.
- Result is registered and held until the next operation completes.

Parameters:
- OPER1_LENGTH, 8, width of OperX (multiplicand / dividend)
- OPER2_LENGTH, 8, width of OperY (multiplier / divisor)

Ports:
- CLK  input  1  clock, rising-edge active
- RST  input  1  asynchronous active-high reset
- Start  input  1  request; sampled only when accepting (IDLE or DONE state)
- Mode  input  1  0 = multiply, 1 = divide; sampled with Start
- OperX  input  OPER1_LENGTH  operand X, sampled with Start
- OperY  input  OPER2_LENGTH  operand Y, sampled with Start
- Busy  output  1  high while an operation is iterating
- Done  output  1  one-cycle pulse; Result valid from this cycle on
- DivByZero  output  1  set with Done when Mode=1 and OperY=0; held with Result
- Result  output  OPER1_LENGTH+OPER2_LENGTH  multiply: full product; divide: {Remainder[OPER2_LENGTH-1:0], Quotient[OPER1_LENGTH-1:0]}

Behaviour:
- Reset (RST=1, asynchronous) forces state IDLE and Busy=0, Done=0, DivByZero=0, Result=0, and clears all internal registers.
  - Reset mid-operation aborts the operation; no Done is produced.
- States: IDLE, RUN, DONE.
  - IDLE: Start=1 latches Mode/OperX/OperY, loads the iteration counter with L, and moves to RUN. Busy=1 from the next cycle.
  - RUN: one iteration per cycle; the counter decrements; on the last iteration move to DONE.
  - DONE: Done=1 and Busy=0 for exactly one cycle; Result/DivByZero update on entry. If Start=1 in DONE, the new operation is accepted (back-to-back, go to RUN); otherwise go to IDLE.
- Iteration count L:
  - multiply: OPER2_LENGTH
  - divide: OPER1_LENGTH
  - divide by zero: 0 (IDLE goes directly to DONE)
- Latency: Start high in cycle 0 gives Done high in cycle L+1. Busy is high in cycles 1..L.
- Start while in RUN is ignored; it causes no queueing and no state change.
- Multiply:
  - Accumulator is OPER1_LENGTH+OPER2_LENGTH bits.
  - Each cycle, if the current LSB of the shifted Y is 1, add X shifted by the iteration index.
  - Product is exact; there is no overflow.
- Divide:
  - Restoring algorithm with an OPER2_LENGTH+1-bit partial remainder.
  - Each cycle, shift in the next dividend bit MSB-first, trial-subtract Y, restore if negative, and shift the quotient bit in.
  - Remainder < Y, so it always fits OPER2_LENGTH bits.
- Divide by zero: Result = all ones, DivByZero=1.
- DivByZero is cleared at the completion of any non-zero-divisor operation.
- Result and DivByZero change only on entry to DONE (or reset). Between operations they hold their last value.

Decomposition:
- Package mul_div_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - constants MODE_MUL=0 and MODE_DIV=1
  - a function computing the counter width, $clog2(max(OPER1_LENGTH, OPER2_LENGTH)+1)
- One sub-module, mul_div_datapath, holds the accumulator/remainder/quotient registers and the add/subtract logic. It is controlled by the top-level FSM through load/step/mode signals.
- The top level contains the FSM, the counter and the output registers.

Test Plan:
- Multiply 13×11, defaults → Busy cycles 1–8, Done in cycle 9, Result=143, DivByZero=0.
- Multiply 255×255 → Result=65025 (0xFE01). Then back-to-back Start in the DONE cycle with 0×200 → Result=0 nine cycles later.
- Divide 200/7 → Done in cycle 9, Result=0x041C (R=4, Q=28). Also divide 5/9 → Result=0x0500 (R=5, Q=0).
- Divide 77/0 → Done in cycle 1, Result=0xFFFF, DivByZero=1. A following multiply 2×3 → Result=6, DivByZero=0.
- During an in-flight 13×11 multiply:
  - Pulse Start with 1×1 at cycle 3 → ignored; Result=143 in cycle 9.
  - Assert RST at cycle 5 → Busy, Done and Result go to 0 immediately; no Done follows.
- OPER1_LENGTH=6, OPER2_LENGTH=3:
  - Multiply 63×7 → Result=441 in cycle 4.
  - Divide 63/5 → Result={3'd3, 6'd12} in cycle 7.
